rxll_fis_rx: RTL and testbench
==============================

RXLL_FIS_RX -- requirements
Module: rxll_fis_rx

Interface
REQ-001 Parameter C_SHADOW_AW, default 3: shadow RAM address width; depth is 2**C_SHADOW_AW dwords.
REQ-002 Parameter C_MAX_DW, default 2049: maximum legal FIS length in dwords, header included.
REQ-003 Parameter C_LEN_W, default 12: width of the length counter and fis_len; must satisfy 2**C_LEN_W > C_MAX_DW.
REQ-004 Parameter C_HDR_FLAG_TYPE, default 8'h46: FIS type whose SOF word is flagged in wr_di[33] and not pushed.
REQ-005 Ports (one clock; reset is synchronous and active-high):
- phyclk  in  1  sole clock.
- phyreset  in  1  synchronous, active-high reset.
- trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n  in  1 each  link-layer frame strobes, active low.
- trn_rd  in  32  frame dword.
- trn_rdst_rdy_n  out  1  backpressure, active low.
- trn_rdst_dsc_n  out  1  tied 1.
- wr_di  out  36  FIFO word: [35] SOF, [34] EOF, [33] flagged header, [32] error, [31:0] data.
- wr_en  out  1  FIFO push.
- wr_almost_full  in  1  FIFO almost full.
- rxfis_raddr  in  C_SHADOW_AW  shadow read address.
- rxfis_rdata  out  32  shadow read data.
- fis_hdr  out  12  trn_rd[11:0] of the last SOF.
- fis_done  out  1  one-cycle frame-complete pulse.
- fis_len  out  C_LEN_W  dwords accepted in the completed frame.
- fis_err  out  3  {overlength, discard, sof_in_frame}, valid with fis_done.
- orphan_cnt  out  8  data beats received outside a frame; saturating.

Function
REQ-006 Beat accepted = !trn_rsrc_rdy_n && !trn_rdst_rdy_n, for SOF, data and EOF alike.
REQ-007 trn_rdst_rdy_n = wr_almost_full OR (state==FRAME AND !trn_rsrc_rdy_n AND !trn_rsof_n), combinational.
REQ-008 States: IDLE, FRAME, DROP; reset state IDLE.
REQ-009 IDLE: an accepted SOF with reof_n=1 enters FRAME; an accepted SOF with reof_n=0 is a one-dword frame and stays in IDLE; an accepted non-SOF beat is dropped and increments orphan_cnt (saturating at 255).
REQ-010 Every accepted in-frame beat produces wr_en=1 one cycle later, with wr_di[31:0]=trn_rd, [35]=SOF and [34]=EOF.
- Exception: a SOF whose trn_rd[7:0]==C_HDR_FLAG_TYPE gives wr_en=0, but wr_di still updates with [33]=1.
REQ-011 Length counter: loads 1 on SOF and increments per accepted beat; it never wraps.
REQ-012 FRAME, accepted beat with reof_n=0: go to IDLE and pulse fis_done next cycle, with fis_len = counter including the EOF beat.
REQ-013 FRAME, SOF seen (stalled per REQ-007): one-cycle pseudo-write of wr_di = {EOF=1, err=1, data=0}, set fis_err[0], pulse fis_done, go to IDLE; the pending SOF is accepted next cycle.
REQ-014 FRAME, trn_rsrc_dsc_n=0: discard takes priority over any simultaneous beat.
- Beat not counted; write {EOF=1, err=1, data=0}, set fis_err[1], pulse fis_done, go to IDLE.
REQ-015 FRAME, accepted beat that would make length exceed C_MAX_DW: write it with EOF=1, err=1, set fis_err[2], pulse fis_done, go to DROP.
REQ-016 DROP: accept and discard beats with no writes; return to IDLE on an accepted EOF or on discard. A SOF in DROP is discarded.
REQ-017 wr_di[32] and [34] are 0 on every non-terminating word; fis_err clears at each SOF.
REQ-018 Shadow RAM: an accepted beat with length index i < 2**C_SHADOW_AW writes trn_rd to ram[i] (header at 0); later beats are not stored; flagged-type headers are stored.
REQ-019 rxfis_rdata = ram[rxfis_raddr], combinational read; RAM contents are not reset.
REQ-020 fis_hdr updates on every accepted SOF, flagged or not.
REQ-021 wr_full and wr_count are not used; the FIFO must absorb at least 2 words after wr_almost_full rises.

Reset
REQ-022 With phyreset=1 at a phyclk edge: state=IDLE; wr_en=0; wr_di=0; fis_done=0; fis_len=0; fis_err=0; fis_hdr=0; orphan_cnt=0; counter=0.
REQ-023 Reset mid-frame: no terminating word is written; the next frame starts clean at SOF.

Verification
REQ-024 3-dword frame, type 0x34, no stall -> wr_di = 0x8_00000034 / 0x0_D1 / 0x4_D2 on 3 consecutive wr_en cycles; fis_done with fis_len=3, fis_err=0; ram[0..2] hold the data.
REQ-025 SOF type 0x46 followed by 2 data beats -> SOF gives wr_en=0 with wr_di[33]=1; 2 words pushed; fis_len=3.
REQ-026 SOF, 1 data beat, then a new SOF -> error-EOF word 0x5_00000000 pushed; fis_err=3'b001; fis_len=2; new frame's SOF accepted one cycle later.
REQ-027 C_MAX_DW=4 with a 6-dword frame -> 4th word has [34]=1 and [32]=1; fis_err=3'b100; beats 5-6 produce no wr_en; state IDLE after EOF.
REQ-028 wr_almost_full=1 for 3 cycles mid-frame -> trn_rdst_rdy_n=1 and no wr_en in those cycles; data order preserved; fis_len unchanged.
REQ-029 300 orphan data beats -> orphan_cnt=255; no wr_en.

Source files
------------

// File: rtl/rxll_fis_rx_if.sv
// Link-layer receive bundle for rxll_fis_rx.
// The master side (link layer) drives the frame strobes and the data dword.
// The slave side (FIS receiver) returns backpressure and the tied-off
// destination discard strobe. All strobes are active low.
//   trn_rsof_n / trn_reof_n  start / end of frame marker for the current beat
//   trn_rsrc_rdy_n           source has a valid beat on trn_rd
//   trn_rsrc_dsc_n           source aborts the frame in progress
//   trn_rd                   frame dword
//   trn_rdst_rdy_n           receiver can take the beat
//   trn_rdst_dsc_n           receiver discard request (always inactive)
interface rxll_fis_rx_if;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic [31:0] trn_rd;
  logic        trn_rdst_rdy_n;
  logic        trn_rdst_dsc_n;

  modport master (
    output trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rd,
    input  trn_rdst_rdy_n, trn_rdst_dsc_n
  );

  modport slave (
    input  trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rd,
    output trn_rdst_rdy_n, trn_rdst_dsc_n
  );
endinterface

// File: rtl/rxll_fis_rx.sv
// FIS receive framer: takes link-layer beats, pushes tagged dwords into a
// downstream FIFO, keeps a shadow copy of the first 2**C_SHADOW_AW dwords of
// each frame and reports length / error status per frame.
// Ports:
//   phyclk, phyreset      clock, synchronous active-high reset
//   trn                   link-layer receive bundle (slave side)
//   wr_di, wr_en          FIFO word {SOF, EOF, flagged hdr, error, data} / push
//   wr_almost_full        FIFO almost full, throttles the link
//   rxfis_raddr/rdata     shadow RAM read port (combinational)
//   fis_hdr               trn_rd[11:0] of the last frame-starting SOF
//   fis_done              one-cycle frame-complete pulse
//   fis_len               dwords accepted in the completed frame
//   fis_err               {overlength, discard, sof_in_frame}
//   orphan_cnt            saturating count of beats seen outside a frame
module rxll_fis_rx #(
  parameter int unsigned C_SHADOW_AW     = 3,
  parameter int unsigned C_MAX_DW        = 2049,
  parameter int unsigned C_LEN_W         = 12,
  parameter logic [7:0]  C_HDR_FLAG_TYPE = 8'h46
) (
  input  logic                   phyclk,
  input  logic                   phyreset,
  rxll_fis_rx_if.slave           trn,
  output logic [35:0]            wr_di,
  output logic                   wr_en,
  input  logic                   wr_almost_full,
  input  logic [C_SHADOW_AW-1:0] rxfis_raddr,
  output logic [31:0]            rxfis_rdata,
  output logic [11:0]            fis_hdr,
  output logic                   fis_done,
  output logic [C_LEN_W-1:0]     fis_len,
  output logic [2:0]             fis_err,
  output logic [7:0]             orphan_cnt
);

  localparam int unsigned          DEPTH   = 1 << C_SHADOW_AW;
  localparam logic [C_LEN_W-1:0]   LEN_MAX = '1;
  localparam logic [C_LEN_W-1:0]   MAX_DW  = C_LEN_W'(C_MAX_DW);
  localparam logic [C_LEN_W-1:0]   LEN_ONE = C_LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DROP
  } state_t;

  state_t             state;
  logic [C_LEN_W-1:0] len_cnt;
  logic [31:0]        ram [0:DEPTH-1];

  logic               sof;
  logic               eof;
  logic               discard;
  logic               stall_sof;
  logic               accept;
  logic               flagged;
  logic [C_LEN_W-1:0] len_inc;
  logic [C_LEN_W-1:0] ram_idx;
  logic               ram_we;

  assign sof     = !trn.trn_rsof_n;
  assign eof     = !trn.trn_reof_n;
  assign discard = !trn.trn_rsrc_dsc_n;
  assign flagged = (trn.trn_rd[7:0] == C_HDR_FLAG_TYPE);

  // A SOF arriving while a frame is open is held off for one cycle so the
  // open frame can be closed with an error word before the new one starts.
  assign stall_sof = (state == ST_FRAME) && !trn.trn_rsrc_rdy_n && sof;

  assign trn.trn_rdst_rdy_n = wr_almost_full | stall_sof;
  assign trn.trn_rdst_dsc_n = 1'b1;

  assign accept  = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
  assign len_inc = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + LEN_ONE;

  // Length index of the current beat: 0 for a frame-starting SOF, otherwise
  // the number of beats already accepted in this frame.
  always_comb begin
    ram_idx = '0;
    ram_we  = 1'b0;
    if (accept) begin
      if (state == ST_IDLE && sof) begin
        ram_idx = '0;
        ram_we  = 1'b1;
      end else if (state == ST_FRAME && !discard) begin
        ram_idx = len_cnt;
        ram_we  = 1'b1;
      end
    end
    if ((ram_idx >> C_SHADOW_AW) != '0) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge phyclk) begin
    if (ram_we) begin
      ram[ram_idx[C_SHADOW_AW-1:0]] <= trn.trn_rd;
    end
  end

  assign rxfis_rdata = ram[rxfis_raddr];

  always_ff @(posedge phyclk) begin
    if (phyreset) begin
      state      <= ST_IDLE;
      len_cnt    <= '0;
      wr_di      <= '0;
      wr_en      <= 1'b0;
      fis_hdr    <= '0;
      fis_done   <= 1'b0;
      fis_len    <= '0;
      fis_err    <= '0;
      orphan_cnt <= '0;
    end else begin
      wr_en    <= 1'b0;
      fis_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (sof) begin
              fis_hdr <= trn.trn_rd[11:0];
              fis_err <= '0;
              len_cnt <= LEN_ONE;
              wr_di   <= {1'b1, eof, flagged, 1'b0, trn.trn_rd};
              wr_en   <= !flagged;
              if (eof) begin
                fis_done <= 1'b1;
                fis_len  <= LEN_ONE;
              end else begin
                state <= ST_FRAME;
              end
            end else if (orphan_cnt != 8'hFF) begin
              orphan_cnt <= orphan_cnt + 8'd1;
            end
          end
        end

        ST_FRAME: begin
          if (discard) begin
            wr_di      <= {4'b0101, 32'h0};
            wr_en      <= 1'b1;
            fis_err[1] <= 1'b1;
            fis_done   <= 1'b1;
            fis_len    <= len_cnt;
            state      <= ST_IDLE;
          end else if (stall_sof) begin
            wr_di      <= {4'b0101, 32'h0};
            wr_en      <= 1'b1;
            fis_err[0] <= 1'b1;
            fis_done   <= 1'b1;
            fis_len    <= len_cnt;
            state      <= ST_IDLE;
          end else if (accept) begin
            len_cnt <= len_inc;
            wr_en   <= 1'b1;
            if (eof) begin
              wr_di    <= {4'b0100, trn.trn_rd};
              fis_done <= 1'b1;
              fis_len  <= len_inc;
              state    <= ST_IDLE;
            end else if (len_inc >= MAX_DW) begin
              // Frame has reached the legal maximum without an EOF, so it
              // can only grow past it: terminate here and swallow the rest.
              wr_di      <= {4'b0101, trn.trn_rd};
              fis_err[2] <= 1'b1;
              fis_done   <= 1'b1;
              fis_len    <= len_inc;
              state      <= ST_DROP;
            end else begin
              wr_di <= {4'b0000, trn.trn_rd};
            end
          end
        end

        ST_DROP: begin
          if (discard) begin
            state <= ST_IDLE;
          end else if (accept) begin
            len_cnt <= len_inc;
            if (eof) begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rxll_fis_rx.sv
// Directed self-checking bench for rxll_fis_rx (C_MAX_DW overridden to 4 so
// the overlength path is reachable with short frames).
module tb_rxll_fis_rx;
  logic        phyclk = 1'b0;
  logic        phyreset;
  logic [35:0] wr_di;
  logic        wr_en;
  logic        wr_almost_full;
  logic [2:0]  rxfis_raddr;
  logic [31:0] rxfis_rdata;
  logic [11:0] fis_hdr;
  logic        fis_done;
  logic [11:0] fis_len;
  logic [2:0]  fis_err;
  logic [7:0]  orphan_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 phyclk = ~phyclk;

  rxll_fis_rx_if trn ();

  rxll_fis_rx #(
    .C_SHADOW_AW    (3),
    .C_MAX_DW       (4),
    .C_LEN_W        (12),
    .C_HDR_FLAG_TYPE(8'h46)
  ) dut (
    .phyclk        (phyclk),
    .phyreset      (phyreset),
    .trn           (trn),
    .wr_di         (wr_di),
    .wr_en         (wr_en),
    .wr_almost_full(wr_almost_full),
    .rxfis_raddr   (rxfis_raddr),
    .rxfis_rdata   (rxfis_rdata),
    .fis_hdr       (fis_hdr),
    .fis_done      (fis_done),
    .fis_len       (fis_len),
    .fis_err       (fis_err),
    .orphan_cnt    (orphan_cnt)
  );

  task automatic tick;
    @(posedge phyclk);
    @(negedge phyclk);
  endtask

  // Active-high stimulus, converted to the active-low strobes.
  task automatic drive(input logic rdy, input logic sof, input logic eof,
                       input logic dsc, input logic [31:0] d);
    trn.trn_rsrc_rdy_n = !rdy;
    trn.trn_rsof_n     = !sof;
    trn.trn_reof_n     = !eof;
    trn.trn_rsrc_dsc_n = !dsc;
    trn.trn_rd         = d;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 32'h0);
    wr_almost_full = 1'b0;
    rxfis_raddr    = 3'd0;
    phyreset       = 1'b1;
    tick; tick;
    phyreset = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_di !== 36'h0) begin errors++; $display("FAIL reset_wr_di got %h want 0", wr_di); end
    checks++; if (fis_done !== 1'b0) begin errors++; $display("FAIL reset_fis_done got %b want 0", fis_done); end
    checks++; if (fis_len !== 12'd0) begin errors++; $display("FAIL reset_fis_len got %0d want 0", fis_len); end
    checks++; if (fis_err !== 3'b000) begin errors++; $display("FAIL reset_fis_err got %b want 000", fis_err); end
    checks++; if (fis_hdr !== 12'h0) begin errors++; $display("FAIL reset_fis_hdr got %h want 0", fis_hdr); end
    checks++; if (orphan_cnt !== 8'd0) begin errors++; $display("FAIL reset_orphan got %0d want 0", orphan_cnt); end
    checks++; if (trn.trn_rdst_rdy_n !== 1'b0) begin errors++; $display("FAIL reset_rdst_rdy_n got %b want 0", trn.trn_rdst_rdy_n); end
    checks++; if (trn.trn_rdst_dsc_n !== 1'b1) begin errors++; $display("FAIL reset_rdst_dsc_n got %b want 1", trn.trn_rdst_dsc_n); end
  endtask

  task automatic test_basic_frame;
    drive(1, 1, 0, 0, 32'h00000034); tick;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_w0_en got %b want 1", wr_en); end
    checks++; if (wr_di !== 36'h800000034) begin errors++; $display("FAIL basic_w0 got %h want 800000034", wr_di); end
    checks++; if (fis_hdr !== 12'h034) begin errors++; $display("FAIL basic_hdr got %h want 034", fis_hdr); end
    drive(1, 0, 0, 0, 32'h000000D1); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h0000000D1) begin errors++; $display("FAIL basic_w1 got en=%b %h want en=1 0000000d1", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", fis_done); end
    drive(1, 0, 1, 0, 32'h000000D2); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h4000000D2) begin errors++; $display("FAIL basic_w2 got en=%b %h want en=1 4000000d2", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", fis_done); end
    checks++; if (fis_len !== 12'd3) begin errors++; $display("FAIL basic_len got %0d want 3", fis_len); end
    checks++; if (fis_err !== 3'b000) begin errors++; $display("FAIL basic_err got %b want 000", fis_err); end
    drive(0, 0, 0, 0, 32'h0); tick;
    checks++; if (wr_en !== 1'b0 || fis_done !== 1'b0) begin errors++; $display("FAIL basic_idle got en=%b done=%b want 0 0", wr_en, fis_done); end
    rxfis_raddr = 3'd0; #1;
    checks++; if (rxfis_rdata !== 32'h34) begin errors++; $display("FAIL basic_ram0 got %h want 00000034", rxfis_rdata); end
    rxfis_raddr = 3'd1; #1;
    checks++; if (rxfis_rdata !== 32'hD1) begin errors++; $display("FAIL basic_ram1 got %h want 000000d1", rxfis_rdata); end
    rxfis_raddr = 3'd2; #1;
    checks++; if (rxfis_rdata !== 32'hD2) begin errors++; $display("FAIL basic_ram2 got %h want 000000d2", rxfis_rdata); end
  endtask

  task automatic test_flagged_hdr;
    drive(1, 1, 0, 0, 32'h00001246); tick;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL flag_sof_en got %b want 0", wr_en); end
    checks++; if (wr_di !== 36'hA00001246) begin errors++; $display("FAIL flag_sof_di got %h want a00001246", wr_di); end
    checks++; if (fis_hdr !== 12'h246) begin errors++; $display("FAIL flag_hdr got %h want 246", fis_hdr); end
    drive(1, 0, 0, 0, 32'h00000011); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h000000011) begin errors++; $display("FAIL flag_w1 got en=%b %h want en=1 000000011", wr_en, wr_di); end
    drive(1, 0, 1, 0, 32'h00000022); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h400000022) begin errors++; $display("FAIL flag_w2 got en=%b %h want en=1 400000022", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_len !== 12'd3) begin errors++; $display("FAIL flag_done got done=%b len=%0d want 1 3", fis_done, fis_len); end
    drive(0, 0, 0, 0, 32'h0); tick;
    rxfis_raddr = 3'd0; #1;
    checks++; if (rxfis_rdata !== 32'h1246) begin errors++; $display("FAIL flag_ram0 got %h want 00001246", rxfis_rdata); end
  endtask

  task automatic test_sof_in_frame;
    drive(1, 1, 0, 0, 32'h00000027); tick;
    drive(1, 0, 0, 0, 32'h00000055); tick;
    checks++; if (wr_di !== 36'h000000055) begin errors++; $display("FAIL sif_w1 got %h want 000000055", wr_di); end
    drive(1, 1, 0, 0, 32'h00000034); #1;
    checks++; if (trn.trn_rdst_rdy_n !== 1'b1) begin errors++; $display("FAIL sif_stall got %b want 1", trn.trn_rdst_rdy_n); end
    tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h500000000) begin errors++; $display("FAIL sif_errword got en=%b %h want en=1 500000000", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_err !== 3'b001 || fis_len !== 12'd2) begin errors++; $display("FAIL sif_status got done=%b err=%b len=%0d want 1 001 2", fis_done, fis_err, fis_len); end
    #1;
    checks++; if (trn.trn_rdst_rdy_n !== 1'b0) begin errors++; $display("FAIL sif_unstall got %b want 0", trn.trn_rdst_rdy_n); end
    tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h800000034) begin errors++; $display("FAIL sif_newsof got en=%b %h want en=1 800000034", wr_en, wr_di); end
    checks++; if (fis_err !== 3'b000 || fis_done !== 1'b0) begin errors++; $display("FAIL sif_errclr got err=%b done=%b want 000 0", fis_err, fis_done); end
    drive(1, 0, 1, 0, 32'h00000099); tick;
    checks++; if (fis_done !== 1'b1 || fis_len !== 12'd2 || fis_err !== 3'b000) begin errors++; $display("FAIL sif_newframe got done=%b len=%0d err=%b want 1 2 000", fis_done, fis_len, fis_err); end
    drive(0, 0, 0, 0, 32'h0); tick;
  endtask

  task automatic test_overlength;
    drive(1, 1, 0, 0, 32'h00000001); tick;
    for (int unsigned i = 2; i <= 3; i++) begin
      drive(1, 0, 0, 0, i); tick;
    end
    drive(1, 0, 0, 0, 32'h00000004); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h500000004) begin errors++; $display("FAIL ovl_w4 got en=%b %h want en=1 500000004", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_err !== 3'b100 || fis_len !== 12'd4) begin errors++; $display("FAIL ovl_status got done=%b err=%b len=%0d want 1 100 4", fis_done, fis_err, fis_len); end
    drive(1, 0, 0, 0, 32'h00000005); tick;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ovl_drop5 got en=%b want 0", wr_en); end
    drive(1, 0, 1, 0, 32'h00000006); tick;
    checks++; if (wr_en !== 1'b0 || fis_done !== 1'b0) begin errors++; $display("FAIL ovl_drop6 got en=%b done=%b want 0 0", wr_en, fis_done); end
    rxfis_raddr = 3'd3; #1;
    checks++; if (rxfis_rdata !== 32'h4) begin errors++; $display("FAIL ovl_ram3 got %h want 00000004", rxfis_rdata); end
    // back in IDLE: a one-dword frame goes straight through
    drive(1, 1, 1, 0, 32'h00000077); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'hC00000077) begin errors++; $display("FAIL ovl_idle_sof got en=%b %h want en=1 c00000077", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_len !== 12'd1 || fis_err !== 3'b000) begin errors++; $display("FAIL ovl_1dw got done=%b len=%0d err=%b want 1 1 000", fis_done, fis_len, fis_err); end
    checks++; if (orphan_cnt !== 8'd0) begin errors++; $display("FAIL ovl_orphan got %0d want 0", orphan_cnt); end
    drive(0, 0, 0, 0, 32'h0); tick;
  endtask

  task automatic test_backpressure;
    drive(1, 1, 0, 0, 32'h000000A0); tick;
    drive(1, 0, 0, 0, 32'h000000B1); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h0000000B1) begin errors++; $display("FAIL bp_w1 got en=%b %h want en=1 0000000b1", wr_en, wr_di); end
    drive(1, 0, 0, 0, 32'h000000B2);
    wr_almost_full = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      checks++; if (trn.trn_rdst_rdy_n !== 1'b1) begin errors++; $display("FAIL bp_rdy_n cyc%0d got %b want 1", i, trn.trn_rdst_rdy_n); end
      tick;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL bp_no_wr cyc%0d got %b want 0", i, wr_en); end
    end
    wr_almost_full = 1'b0; tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h0000000B2) begin errors++; $display("FAIL bp_w2 got en=%b %h want en=1 0000000b2", wr_en, wr_di); end
    drive(1, 0, 1, 0, 32'h000000B3); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h4000000B3) begin errors++; $display("FAIL bp_w3 got en=%b %h want en=1 4000000b3", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_len !== 12'd4 || fis_err !== 3'b000) begin errors++; $display("FAIL bp_status got done=%b len=%0d err=%b want 1 4 000", fis_done, fis_len, fis_err); end
    drive(0, 0, 0, 0, 32'h0); tick;
  endtask

  task automatic test_discard;
    drive(1, 1, 0, 0, 32'h00000010); tick;
    drive(1, 0, 0, 0, 32'h00000011); tick;
    drive(1, 0, 0, 1, 32'h00000012); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h500000000) begin errors++; $display("FAIL dsc_word got en=%b %h want en=1 500000000", wr_en, wr_di); end
    checks++; if (fis_done !== 1'b1 || fis_err !== 3'b010 || fis_len !== 12'd2) begin errors++; $display("FAIL dsc_status got done=%b err=%b len=%0d want 1 010 2", fis_done, fis_err, fis_len); end
    drive(0, 0, 0, 0, 32'h0); tick;
    checks++; if (wr_en !== 1'b0 || fis_done !== 1'b0) begin errors++; $display("FAIL dsc_after got en=%b done=%b want 0 0", wr_en, fis_done); end
  endtask

  task automatic test_reset_mid_frame;
    drive(1, 1, 0, 0, 32'h00000020); tick;
    drive(1, 0, 0, 0, 32'h00000021); tick;
    drive(0, 0, 0, 0, 32'h0);
    phyreset = 1'b1; tick;
    phyreset = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_di !== 36'h0 || fis_hdr !== 12'h0) begin errors++; $display("FAIL rmf_reset got en=%b di=%h hdr=%h want 0 0 0", wr_en, wr_di, fis_hdr); end
    tick;
    checks++; if (wr_en !== 1'b0 || fis_done !== 1'b0) begin errors++; $display("FAIL rmf_noterm got en=%b done=%b want 0 0", wr_en, fis_done); end
    drive(1, 1, 0, 0, 32'h00000030); tick;
    checks++; if (wr_en !== 1'b1 || wr_di !== 36'h800000030) begin errors++; $display("FAIL rmf_sof got en=%b %h want en=1 800000030", wr_en, wr_di); end
    drive(1, 0, 1, 0, 32'h00000031); tick;
    checks++; if (fis_done !== 1'b1 || fis_len !== 12'd2 || fis_err !== 3'b000) begin errors++; $display("FAIL rmf_frame got done=%b len=%0d err=%b want 1 2 000", fis_done, fis_len, fis_err); end
    drive(0, 0, 0, 0, 32'h0); tick;
  endtask

  task automatic test_orphans;
    logic saw_wr;
    saw_wr = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      drive(1, 0, i[0], 0, i); tick;
      if (wr_en !== 1'b0) saw_wr = 1'b1;
      if (i == 253) begin
        checks++; if (orphan_cnt !== 8'd254) begin errors++; $display("FAIL orphan_254 got %0d want 254", orphan_cnt); end
      end
    end
    drive(0, 0, 0, 0, 32'h0); tick;
    checks++; if (orphan_cnt !== 8'd255) begin errors++; $display("FAIL orphan_sat got %0d want 255", orphan_cnt); end
    checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL orphan_no_wr got %b want 0", saw_wr); end
  endtask

  initial begin
    wr_almost_full = 1'b0;
    rxfis_raddr    = 3'd0;
    phyreset       = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    @(negedge phyclk);
    test_reset;
    test_basic_frame;
    test_flagged_hdr;
    test_sof_in_frame;
    test_overlength;
    test_backpressure;
    test_discard;
    test_reset_mid_frame;
    test_orphans;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
